// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core front end.
package core_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef enum logic {
        MISALIGNED   = 1'b0,
        OUT_OF_RANGE = 1'b1
    } fetch_fault_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic         fault;
        fetch_fault_e cause;
    } fetch_check_t;

    // Misalignment takes precedence over an out-of-range word index.
    function automatic fetch_check_t pc_check(input logic [XLEN-1:0] pc,
                                              input logic [31:0]     imem_words);
        fetch_check_t res;
        res.fault = 1'b0;
        res.cause = MISALIGNED;
        if (pc[1:0] != 2'b00) begin
            res.fault = 1'b1;
            res.cause = MISALIGNED;
        end else if ({2'b00, pc[XLEN-1:2]} >= imem_words) begin
            res.fault = 1'b1;
            res.cause = OUT_OF_RANGE;
        end else begin
            res.fault = 1'b0;
            res.cause = MISALIGNED;
        end
        return res;
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch unit bus: instruction memory port, decode handshake, redirect and fault report.
interface ifetch_unit_if;
    import core_pkg::*;

    logic [XLEN-1:0] iaddr;
    logic [ILEN-1:0] idata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            fault_valid;
    logic [XLEN-1:0] fault_pc;
    fetch_fault_e    fault_cause;

    modport master (
        output iaddr, out_valid, out_pc, out_instr, fault_valid, fault_pc, fault_cause,
        input  idata, out_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  iaddr, out_valid, out_pc, out_instr, fault_valid, fault_pc, fault_cause,
        output idata, out_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/ifetch_fifo.sv
// Circular fetch buffer of {pc, instr} entries; flush wins over push and pop.
module ifetch_fifo
    import core_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  din,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_pop_s;
    logic          do_push_s;

    // Guard against underflow and overflow regardless of caller behaviour.
    always_comb begin
        do_pop_s  = pop && (count_r != {CW{1'b0}});
        do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end

    // Pointer, occupancy and storage update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch initiator: PC, imem addressing, fetch buffer and fault reporting.
module ifetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              IMEM_WORDS = 32,
    parameter int              DEPTH      = 2
) (
    input logic           clk,
    input logic           rst,
    ifetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t    state_r;
    logic [XLEN-1:0] pc_r;
    logic            fault_valid_r;
    logic [XLEN-1:0] fault_pc_r;
    fetch_fault_e    fault_cause_r;

    logic [CW-1:0]   count_s;
    fetch_entry_t    head_s;
    fetch_entry_t    din_s;
    fetch_check_t    check_s;
    logic            out_valid_s;
    logic            pop_s;
    logic            room_s;
    logic            fetch_s;
    logic            fault_hit_s;

    // A fetch attempt needs buffer room this cycle; a fault replaces the push.
    always_comb begin
        out_valid_s = (count_s != {CW{1'b0}});
        pop_s       = out_valid_s && bus.out_ready;
        room_s      = (count_s < CW'(DEPTH)) || pop_s;
        check_s     = pc_check(pc_r, 32'(IMEM_WORDS));
        din_s.pc    = pc_r;
        din_s.instr = bus.idata;
        fetch_s     = 1'b0;
        fault_hit_s = 1'b0;
        if ((state_r == RUN) && room_s && !bus.redirect_valid) begin
            fetch_s     = !check_s.fault;
            fault_hit_s = check_s.fault;
        end else begin
            fetch_s     = 1'b0;
            fault_hit_s = 1'b0;
        end
    end

    // Fetch FSM: redirect overrides everything, including a held fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= RUN;
            pc_r          <= RESET_PC;
            fault_valid_r <= 1'b0;
            fault_pc_r    <= {XLEN{1'b0}};
            fault_cause_r <= MISALIGNED;
        end else if (bus.redirect_valid) begin
            state_r       <= RUN;
            pc_r          <= bus.redirect_pc;
            fault_valid_r <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (fault_hit_s) begin
                        state_r       <= FAULT;
                        fault_valid_r <= 1'b1;
                        fault_pc_r    <= pc_r;
                        fault_cause_r <= check_s.cause;
                    end else if (fetch_s) begin
                        pc_r <= pc_r + 32'd4;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                FAULT: begin
                    state_r <= FAULT;
                end
                default: begin
                    state_r <= RUN;
                end
            endcase
        end
    end

    ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fetch_s),
        .pop   (pop_s),
        .flush (bus.redirect_valid),
        .din   (din_s),
        .head  (head_s),
        .count (count_s)
    );

    assign bus.iaddr       = pc_r;
    assign bus.out_valid   = out_valid_s;
    assign bus.out_pc      = head_s.pc;
    assign bus.out_instr   = head_s.instr;
    assign bus.fault_valid = fault_valid_r;
    assign bus.fault_pc    = fault_pc_r;
    assign bus.fault_cause = fault_cause_r;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed and randomized bench for ifetch_unit against a queue-based reference model.
module tb_ifetch_unit;
    import core_pkg::*;

    localparam int MDEPTH = 2;
    localparam int MWORDS = 32;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ref_ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem [MWORDS];

    int          checks = 0;
    int          errors = 0;

    ref_ent_t    m_q[$];
    logic [31:0] m_pc;
    logic        m_fault;
    logic [31:0] m_fault_pc;
    logic        m_fault_cause;

    ifetch_unit_if bus ();

    ifetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (MWORDS),
        .DEPTH      (MDEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.idata = (bus.iaddr[31:2] < 30'd32) ? imem[bus.iaddr[6:2]] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc          = 32'h0;
        m_fault       = 1'b0;
        m_fault_pc    = 32'h0;
        m_fault_cause = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_iaddr", bus.iaddr, 32'h0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_out_instr", bus.out_instr, 32'h0);
        chk("rst_fault_valid", {31'd0, bus.fault_valid}, 32'd0);
        chk("rst_fault_pc", bus.fault_pc, 32'h0);
        chk("rst_fault_cause", {31'd0, bus.fault_cause}, 32'd0);
    endtask

    task automatic check_outputs();
        chk("iaddr", bus.iaddr, m_pc);
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            chk("out_pc", bus.out_pc, m_q[0].pc);
            chk("out_instr", bus.out_instr, m_q[0].instr);
        end
        chk("fault_valid", {31'd0, bus.fault_valid}, {31'd0, m_fault});
        if (m_fault) begin
            chk("fault_pc", bus.fault_pc, m_fault_pc);
            chk("fault_cause", {31'd0, bus.fault_cause}, {31'd0, m_fault_cause});
        end
    endtask

    // One clock of the reference behaviour, written in terms of the queue.
    task automatic model_step(input logic rdy, input logic rv, input logic [31:0] rpc);
        ref_ent_t e;
        if (rv) begin
            m_q.delete();
            m_pc    = rpc;
            m_fault = 1'b0;
        end else begin
            if (rdy && m_q.size() != 0) void'(m_q.pop_front());
            if (!m_fault && m_q.size() < MDEPTH) begin
                if (m_pc % 4 != 0) begin
                    m_fault = 1'b1; m_fault_pc = m_pc; m_fault_cause = 1'b0;
                end else if (m_pc / 4 >= MWORDS) begin
                    m_fault = 1'b1; m_fault_pc = m_pc; m_fault_cause = 1'b1;
                end else begin
                    e.pc    = m_pc;
                    e.instr = imem[m_pc / 4];
                    m_q.push_back(e);
                    m_pc    = m_pc + 32'd4;
                end
            end
        end
    endtask

    // Called at a falling edge: check, drive, advance model, move to next falling edge.
    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        check_outputs();
        bus.out_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        model_step(rdy, rv, rpc);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] tgt;
        for (int i = 0; i < MWORDS; i++) imem[i] = $urandom;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        model_reset();

        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;

        // Streaming with out_ready held high.
        repeat (10) cycle(1'b1, 1'b0, 32'h0);

        // Back-pressure from a fresh start.
        rst = 1'b1; #1; model_reset(); @(negedge clk); rst = 1'b0;
        cycle(1'b0, 1'b0, 32'h0);
        repeat (5) cycle(1'b0, 1'b0, 32'h0);
        chk("stall_iaddr", bus.iaddr, 32'h8);
        chk("stall_head_pc", bus.out_pc, 32'h0);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);

        // Redirect while full with a same-cycle pop.
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h40);
        chk("redir_iaddr", bus.iaddr, 32'h40);
        chk("redir_bubble", {31'd0, bus.out_valid}, 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("redir_head", bus.out_pc, 32'h40);
        repeat (3) cycle(1'b1, 1'b0, 32'h0);

        // Misaligned target, then recovery.
        cycle(1'b1, 1'b1, 32'h42);
        repeat (3) cycle(1'b1, 1'b0, 32'h0);
        chk("misal_pc", bus.fault_pc, 32'h42);
        chk("misal_cause", {31'd0, bus.fault_cause}, 32'd0);
        cycle(1'b1, 1'b1, 32'h10);
        cycle(1'b1, 1'b0, 32'h0);
        chk("recover_head", bus.out_pc, 32'h10);

        // Run off the end of instruction memory.
        repeat (34) cycle(1'b1, 1'b0, 32'h0);
        chk("oor_valid", {31'd0, bus.fault_valid}, 32'd1);
        chk("oor_pc", bus.fault_pc, 32'h80);
        chk("oor_cause", {31'd0, bus.fault_cause}, 32'd1);

        // Randomized traffic with occasional redirects.
        for (int i = 0; i < 400; i++) begin
            tgt = 32'($urandom_range(0, 36)) * 32'd4;
            if ($urandom_range(0, 9) == 0) tgt = tgt + 32'd2;
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), tgt);
        end

        // Asynchronous reset mid-stream with a pending redirect.
        cycle(1'b1, 1'b1, 32'h10);
        repeat (5) cycle(1'b1, 1'b0, 32'h0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h20;
        #2 rst = 1'b1;
        #1 check_reset_values();
        model_reset();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) cycle(1'b1, 1'b0, 32'h0);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
